anim_step_ctrl: RTL and testbench
=================================

Name: anim_step_ctrl

Overview:
- Consumer end of the animation clock divider.
- Takes the slow toggling animation level from the divider and synchronises it into the CLK domain.
- Converts each toggle into an animation step request. Steps are queued and offered to game logic (ball/paddle update) over a valid/ready handshake.
- Keeps a frame counter and flags overruns when the game logic falls behind.

Parameters:
- SYNC_STAGES, 2, flip-flops in the anim_in synchroniser chain (min 2).
- BOTH_EDGES, 1, 1: every toggle of anim_in is a tick; 0: rising edges only.
- FRAME_W, 16, width of frame_cnt.
- PEND_W, 3, width of pending step counter (max 2^PEND_W-1 queued steps).

Ports:
- CLK  in  1  system clock.
- RST  in  1  synchronous, active-high reset.
- anim_in  in  1  toggling animation level from divider, treated as asynchronous.
- enable  in  1  1 = accept ticks; 0 = discard ticks and flush the queue.
- step_valid  out  1  a step is offered to game logic.
- step_ready  in  1  game logic accepts the step.
- frame_cnt  out  FRAME_W  count of accepted steps, wraps.
- pending  out  PEND_W  steps not yet accepted, including the one being offered.
- overrun  out  1  sticky: a tick arrived while pending was saturated.
- clr_overrun  in  1  clears overrun.

Behaviour:
- Reset (RST=1 at a CLK edge) values:
  - sync chain and edge register = 0
  - prime counter = 0
  - FSM = IDLE
  - step_valid = 0, frame_cnt = 0, pending = 0, overrun = 0
- Edge detection:
  - tick = sync_out ^ prev when BOTH_EDGES=1.
  - tick = sync_out & ~prev when BOTH_EDGES=0.
  - prev <= sync_out every cycle.
  - tick is masked for the first SYNC_STAGES+1 cycles after reset release (priming), so a high anim_in at reset produces no tick.
- Latency: anim_in change sampled at edge N → tick valid during cycle after edge N+SYNC_STAGES → pending incremented at edge N+SYNC_STAGES+1 → step_valid high after edge N+SYNC_STAGES+2 (if the FSM was IDLE).
- Pending counter, per cycle; hs = step_valid & step_ready:
  - tick & enable & !hs: pending+1. If pending is already max, hold and set overrun.
  - hs & !(tick & enable): pending-1.
  - tick & enable & hs: unchanged (also when saturated; no overrun).
  - enable=0: pending <= step_valid ? 1 : 0. The in-flight step is never retracted; queued steps are dropped; ticks are ignored.
- FSM states IDLE, OFFER:
  - IDLE: step_valid=0. Go to OFFER when pending != 0.
  - OFFER: step_valid=1, held stable until hs.
    - On hs: frame_cnt+1, wrapping from 2^FRAME_W-1 to 0.
    - Stay in OFFER if pending after this cycle's update is != 0 (back-to-back: one step per cycle when step_ready stays high).
    - Otherwise go to IDLE.
  - step_valid must never drop without hs, including when enable falls mid-offer.
- overrun: set on a saturated tick. clr_overrun clears it. Set wins over clear in the same cycle.
- Reset mid-offer: everything returns to reset values next cycle. No handshake completes on that edge.
- Toggle frequency is assumed far below CLK. Toggles closer than SYNC_STAGES+1 cycles apart may merge, which is acceptable.

Decomposition:
- Shared package anim_pkg holds:
  - FSM state encoding: IDLE=1'b0, OFFER=1'b1.
  - Defaults: ANIM_SYNC_STAGES=2, ANIM_FRAME_W=16.
- One natural sub-module: anim_sync_edge. It contains the synchroniser chain, prime masking and the tick pulse. It takes CLK, RST, anim_in and outputs tick; parameters are SYNC_STAGES and BOTH_EDGES.
- The FSM, pending counter, frame counter and overrun logic live in the top module.

Test Plan:
- Reset with anim_in=1 held → no step_valid within 20 cycles; pending=0.
- enable=1, step_ready=1, toggle anim_in 0→1 at edge 10 → step_valid high exactly one cycle, after edge 14; frame_cnt 0→1; pending returns to 0.
- BOTH_EDGES=0: toggles 0→1→0→1 spaced 20 cycles → frame_cnt=2. With BOTH_EDGES=1 the same stimulus gives frame_cnt=3.
- step_ready=0, 9 toggles spaced 10 cycles:
  - pending saturates at 7 and overrun=1; step_valid stays high.
  - Then step_ready=1 → 7 back-to-back accepted cycles; frame_cnt=7; pending=0.
  - clr_overrun → overrun=0.
- pending=3 with step_valid=1, deassert enable → step_valid held until step_ready=1. After hs: pending=0, frame_cnt+1, FSM back to IDLE. Toggles during enable=0 change nothing.
- Preload frame_cnt to 16'hFFFF via 65535 steps (or a force), accept one more step → frame_cnt=0. Then tick and hs in the same cycle with pending=7 → pending stays 7, overrun stays 0.

Source files
------------

// File: rtl/anim_pkg.sv
// anim_pkg: shared types and defaults for the animation step controller slice.
//   anim_state_e      - handshake FSM state encoding (IDLE / OFFER)
//   ANIM_SYNC_STAGES  - default depth of the anim_in synchroniser
//   ANIM_FRAME_W      - default width of the accepted-step frame counter
//   ANIM_PEND_W       - default width of the queued-step counter
package anim_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    OFFER = 1'b1
  } anim_state_e;

  localparam int ANIM_SYNC_STAGES = 2;
  localparam int ANIM_FRAME_W     = 16;
  localparam int ANIM_PEND_W      = 3;

endpackage

// File: rtl/anim_step_ctrl_if.sv
// anim_step_ctrl_if: step handshake between the animation step controller and
// the game logic that consumes steps (ball/paddle update).
//   step_valid - a step is on offer (driven by the controller)
//   step_ready - game logic takes the step this cycle (driven by game logic)
// Modports: master = controller side, slave = game-logic side.
interface anim_step_ctrl_if;

  logic step_valid;
  logic step_ready;

  modport master (output step_valid, input step_ready);
  modport slave  (input step_valid, output step_ready);

endinterface

// File: rtl/anim_sync_edge.sv
// anim_sync_edge: brings the slow, asynchronous anim_in level into the CLK
// domain and turns its transitions into one-cycle tick pulses.
//   CLK     - system clock
//   RST     - synchronous, active-high reset
//   anim_in - toggling animation level from the divider (asynchronous)
//   tick    - registered one-cycle pulse per detected edge of anim_in
// Parameters: SYNC_STAGES (>= 2) synchroniser depth; BOTH_EDGES selects
// toggle detection (1) or rising edges only (0).
module anim_sync_edge
  import anim_pkg::*;
#(
  parameter int SYNC_STAGES = ANIM_SYNC_STAGES,
  parameter bit BOTH_EDGES  = 1'b1
) (
  input  logic CLK,
  input  logic RST,
  input  logic anim_in,
  output logic tick
);

  // The edge detector sees valid history only once the chain and prev_q have
  // been refilled after reset; until then every comparison is suppressed.
  localparam int PRIME_N = SYNC_STAGES + 1;
  localparam int PRIME_W = $clog2(PRIME_N + 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  logic [PRIME_W-1:0]     prime_cnt;
  logic                   sync_out;
  logic                   primed;
  logic                   raw_tick;

  assign sync_out = sync_q[SYNC_STAGES-1];
  assign primed   = (prime_cnt == PRIME_W'(PRIME_N));
  assign raw_tick = BOTH_EDGES ? (sync_out ^ prev_q) : (sync_out & ~prev_q);

  // NOTE: state is updated with <= so every flop samples the pre-edge values
  // of its neighbours; blocking assignments here would collapse the chain.
  always_ff @(posedge CLK) begin
    if (RST) begin
      sync_q    <= '0;
      prev_q    <= 1'b0;
      prime_cnt <= '0;
      tick      <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], anim_in};
      prev_q <= sync_out;
      if (!primed) prime_cnt <= prime_cnt + 1'b1;
      tick <= raw_tick & primed;
    end
  end

endmodule

// File: rtl/anim_step_ctrl.sv
// anim_step_ctrl: consumer end of the animation clock divider. Each detected
// anim_in edge becomes a queued step, offered to game logic over a
// valid/ready handshake, one step per cycle when step_ready stays high.
//   CLK, RST    - system clock, synchronous active-high reset
//   anim_in     - asynchronous animation level from the divider
//   enable      - 1: accept ticks; 0: drop ticks and flush queued steps
//   step_if     - step_valid / step_ready handshake (master side)
//   frame_cnt   - accepted steps, wrapping
//   pending     - steps not yet accepted, including the one on offer
//   overrun     - sticky: a tick arrived while pending was saturated
//   clr_overrun - clears overrun (a same-cycle set takes priority)
module anim_step_ctrl
  import anim_pkg::*;
#(
  parameter int SYNC_STAGES = ANIM_SYNC_STAGES,
  parameter bit BOTH_EDGES  = 1'b1,
  parameter int FRAME_W     = ANIM_FRAME_W,
  parameter int PEND_W      = ANIM_PEND_W
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               anim_in,
  input  logic               enable,
  anim_step_ctrl_if.master   step_if,
  output logic [FRAME_W-1:0] frame_cnt,
  output logic [PEND_W-1:0]  pending,
  output logic               overrun,
  input  logic               clr_overrun
);

  localparam logic [PEND_W-1:0] PEND_MAX = '1;

  anim_state_e       state_q;
  anim_state_e       state_d;
  logic [PEND_W-1:0] pending_d;
  logic              tick;
  logic              tick_en;
  logic              hs;
  logic              step_valid;
  logic              sat_tick;

  anim_sync_edge #(
    .SYNC_STAGES (SYNC_STAGES),
    .BOTH_EDGES  (BOTH_EDGES)
  ) u_sync_edge (
    .CLK     (CLK),
    .RST     (RST),
    .anim_in (anim_in),
    .tick    (tick)
  );

  // step_valid is a pure function of state, so it cannot glitch or drop
  // except through a state change.
  assign step_valid         = (state_q == OFFER);
  assign step_if.step_valid = step_valid;
  assign hs                 = step_valid & step_if.step_ready;
  assign tick_en            = tick & enable;
  assign sat_tick           = tick_en & ~hs & (pending == PEND_MAX);

  // NOTE: every always_comb output gets a default before any branch so no
  // path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    pending_d = pending;
    if (!enable) begin
      // Flush: only a step already on offer and not taken this cycle survives.
      pending_d = (step_valid && !hs) ? PEND_W'(1) : '0;
    end else if (tick_en && !hs) begin
      if (pending != PEND_MAX) pending_d = pending + 1'b1;
    end else if (hs && !tick_en) begin
      pending_d = pending - 1'b1;
    end
  end

  // Next state looks at pending_d so a flush while idle does not start an
  // offer for a step that is being dropped on the same edge.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (pending != '0 && pending_d != '0) state_d = OFFER;
      OFFER:   if (pending_d == '0) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= IDLE;
      pending   <= '0;
      frame_cnt <= '0;
      overrun   <= 1'b0;
    end else begin
      state_q <= state_d;
      pending <= pending_d;
      if (hs) frame_cnt <= frame_cnt + 1'b1;
      if (sat_tick)         overrun <= 1'b1;
      else if (clr_overrun) overrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_anim_step_ctrl.sv
// tb_anim_step_ctrl: bench for anim_step_ctrl. The main instance uses both-edge
// detection and a 16-bit frame counter; a second rising-edge-only instance
// with a 4-bit frame counter shares anim_in/enable and exercises edge mode
// and frame wrap. Steps the bench expects are queued with their frame number;
// a monitor pops and compares on every observed handshake.
module tb_anim_step_ctrl;
  import anim_pkg::*;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        anim_in = 1'b0;
  logic        enable = 1'b0;
  logic        clr_overrun = 1'b0;
  logic [15:0] frame_cnt;
  logic [2:0]  pending;
  logic        overrun;
  logic [3:0]  re_frame;
  logic [2:0]  re_pending;
  logic        re_overrun;

  anim_step_ctrl_if m_if ();
  anim_step_ctrl_if re_if ();

  always #5 CLK = ~CLK;

  anim_step_ctrl #(.BOTH_EDGES(1'b1), .FRAME_W(16), .PEND_W(3)) dut (
    .CLK(CLK), .RST(RST), .anim_in(anim_in), .enable(enable), .step_if(m_if),
    .frame_cnt(frame_cnt), .pending(pending), .overrun(overrun),
    .clr_overrun(clr_overrun)
  );

  anim_step_ctrl #(.BOTH_EDGES(1'b0), .FRAME_W(4), .PEND_W(3)) dut_re (
    .CLK(CLK), .RST(RST), .anim_in(anim_in), .enable(enable), .step_if(re_if),
    .frame_cnt(re_frame), .pending(re_pending), .overrun(re_overrun),
    .clr_overrun(clr_overrun)
  );

  int errors = 0;
  int checks = 0;
  int exp_q[$];        // expected frame_cnt value at each future handshake
  int model_frame = 0; // steps the main instance will have accepted
  int re_model = 0;    // accepted rising edges, modulo 16
  logic prev_hold = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic push_steps(input int n);
    repeat (n) begin
      exp_q.push_back(model_frame);
      model_frame = (model_frame + 1) % 65536;
    end
  endtask

  // Flip anim_in, credit the rising-edge instance if it will take the step.
  task automatic toggle(input int gap);
    if (!anim_in && enable) re_model = (re_model + 1) % 16;
    anim_in = ~anim_in;
    cyc(gap);
  endtask

  task automatic rise();
    if (anim_in) begin
      push_steps(1);
      toggle(10);
    end
    push_steps(1);
    toggle(10);
  endtask

  task automatic do_reset(input logic level);
    RST = 1'b1;
    anim_in = level;
    enable = 1'b1;
    clr_overrun = 1'b0;
    m_if.step_ready = 1'b0;
    re_if.step_ready = 1'b1;
    cyc(3);
    @(negedge CLK);
    check("rst_step_valid", int'(m_if.step_valid), 0);
    check("rst_pending", int'(pending), 0);
    check("rst_frame_cnt", int'(frame_cnt), 0);
    check("rst_overrun", int'(overrun), 0);
    check("rst_re_frame", int'(re_frame), 0);
    exp_q.delete();
    model_frame = 0;
    re_model = 0;
    cyc(1);
    RST = 1'b0;
  endtask

  // Scoreboard monitor: frame number at each handshake, and valid stability.
  always @(negedge CLK) begin
    if (prev_hold) check("valid_held_until_hs", int'(m_if.step_valid), 1);
    if (!RST && m_if.step_valid && m_if.step_ready) begin
      if (exp_q.size() == 0) check("unexpected_step", 1, 0);
      else check("step_frame", int'(frame_cnt), exp_q.pop_front());
    end
    prev_hold = !RST && m_if.step_valid && !m_if.step_ready;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no summary by time limit, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int seen;
    logic [7:0] vbits;
    logic en;

    m_if.step_ready = 1'b0;
    re_if.step_ready = 1'b1;

    // High anim_in through reset must not produce a step.
    do_reset(1'b1);
    seen = 0;
    repeat (20) begin
      @(negedge CLK);
      if (m_if.step_valid) seen++;
    end
    check("no_step_after_reset", seen, 0);
    check("pending_after_reset", int'(pending), 0);
    cyc(1);

    // Latency: step_valid high for exactly the cycle after edge N+4.
    do_reset(1'b0);
    m_if.step_ready = 1'b1;
    cyc(10);
    push_steps(1);
    toggle(0);
    for (int k = 0; k < 8; k++) begin
      @(posedge CLK);
      @(negedge CLK);
      vbits[k] = m_if.step_valid;
    end
    check("latency_window", int'(vbits), 8'b0001_0000);
    check("latency_pending", int'(pending), 0);
    check("latency_frame", int'(frame_cnt), 1);
    cyc(1);

    // 0->1->0->1: three toggles, two rising edges.
    do_reset(1'b0);
    m_if.step_ready = 1'b1;
    cyc(5);
    push_steps(3);
    repeat (3) toggle(20);
    @(negedge CLK);
    check("both_edges_frames", int'(frame_cnt), 3);
    check("rise_only_frames", int'(re_frame), 2);
    cyc(1);

    // Saturation: 9 ticks with no acceptance, then drain back-to-back.
    m_if.step_ready = 1'b0;
    push_steps(7);
    repeat (9) toggle(10);
    @(negedge CLK);
    check("sat_pending", int'(pending), 7);
    check("sat_overrun", int'(overrun), 1);
    check("sat_valid", int'(m_if.step_valid), 1);
    cyc(1);
    m_if.step_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge CLK);
      vbits[k] = m_if.step_valid;
    end
    check("drain_b2b", int'(vbits), 8'b0111_1111);
    check("drain_pending", int'(pending), 0);
    check("drain_frame", int'(frame_cnt), model_frame);
    check("overrun_sticky", int'(overrun), 1);
    cyc(1);
    clr_overrun = 1'b1;
    cyc(1);
    clr_overrun = 1'b0;
    @(negedge CLK);
    check("overrun_cleared", int'(overrun), 0);
    cyc(1);

    // Refill to saturation; set beats clear; tick+hs keeps pending at max.
    m_if.step_ready = 1'b0;
    push_steps(7);
    repeat (7) toggle(10);
    @(negedge CLK);
    check("refill_pending", int'(pending), 7);
    check("refill_overrun", int'(overrun), 0);
    cyc(1);
    toggle(3);
    clr_overrun = 1'b1;
    cyc(1);
    clr_overrun = 1'b0;
    @(negedge CLK);
    check("set_beats_clear", int'(overrun), 1);
    cyc(1);
    clr_overrun = 1'b1;
    cyc(1);
    clr_overrun = 1'b0;
    cyc(8);
    push_steps(1);
    toggle(3);
    m_if.step_ready = 1'b1;
    cyc(1);
    m_if.step_ready = 1'b0;
    @(negedge CLK);
    check("tick_hs_pending", int'(pending), 7);
    check("tick_hs_overrun", int'(overrun), 0);
    cyc(1);
    m_if.step_ready = 1'b1;
    cyc(10);
    @(negedge CLK);
    check("redrain_pending", int'(pending), 0);
    cyc(1);

    // Enable falls mid-offer: the offered step survives, the rest are dropped.
    m_if.step_ready = 1'b0;
    push_steps(1);
    repeat (3) toggle(10);
    @(negedge CLK);
    check("pre_flush_pending", int'(pending), 3);
    cyc(1);
    enable = 1'b0;
    cyc(2);
    @(negedge CLK);
    check("flush_pending", int'(pending), 1);
    check("flush_valid", int'(m_if.step_valid), 1);
    cyc(1);
    toggle(10);
    toggle(10);
    @(negedge CLK);
    check("disabled_ticks_pending", int'(pending), 1);
    cyc(1);
    m_if.step_ready = 1'b1;
    cyc(1);
    m_if.step_ready = 1'b0;
    cyc(5);
    @(negedge CLK);
    check("post_flush_pending", int'(pending), 0);
    check("post_flush_idle", int'(m_if.step_valid), 0);
    check("post_flush_frame", int'(frame_cnt), model_frame);
    cyc(1);
    enable = 1'b1;

    // Reset while a step is on offer.
    toggle(10);
    @(negedge CLK);
    check("pre_reset_offer", int'(m_if.step_valid), 1);
    cyc(1);
    RST = 1'b1;
    cyc(1);
    @(negedge CLK);
    check("midreset_valid", int'(m_if.step_valid), 0);
    check("midreset_pending", int'(pending), 0);
    check("midreset_frame", int'(frame_cnt), 0);
    exp_q.delete();
    model_frame = 0;
    re_model = 0;
    cyc(1);
    RST = 1'b0;
    cyc(5);

    // Randomised segments: enable, idle gap and back-pressure vary.
    for (int s = 0; s < 40; s++) begin
      en = ($urandom_range(0, 3) != 0);
      enable = en;
      cyc(2 + $urandom_range(0, 5));
      if (en) push_steps(1);
      toggle(0);
      repeat (30) begin
        m_if.step_ready = 1'($urandom_range(0, 1));
        cyc(1);
      end
      m_if.step_ready = 1'b1;
      cyc(10);
    end
    enable = 1'b1;
    @(negedge CLK);
    check("random_drained", exp_q.size(), 0);
    check("random_frame", int'(frame_cnt), model_frame);
    check("random_re_frame", int'(re_frame), re_model);
    check("random_pending", int'(pending), 0);
    cyc(1);

    // Frame counter wrap on the 4-bit rising-edge instance.
    while (re_model != 15) rise();
    @(negedge CLK);
    check("re_frame_max", int'(re_frame), 15);
    cyc(1);
    rise();
    @(negedge CLK);
    check("re_frame_wrap", int'(re_frame), 0);
    cyc(5);
    check("final_drained", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
